// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bus arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    localparam int CNT_W = 4;

    function automatic int unsigned burst_len(hburst_e b);
        int unsigned n;
        n = 1;
        unique case (b)
            WRAP4, INCR4:   n = 4;
            WRAP8, INCR8:   n = 8;
            WRAP16, INCR16: n = 16;
            default:        n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// Round-robin priority picker: first requester after ptr wins, wrapping.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         vld
);

    logic [W-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB arbiter: round-robin with parked default master; bursts and
// locked sequences are never broken, handover only on Hready.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MW-1:0]          Hmaster,
    output logic                   Hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DEF_GNT =
        NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    function automatic logic [MW-1:0] oh2idx(logic [NUM_MASTERS-1:0] v);
        logic [MW-1:0] r;
        logic [MW-1:0] k;
        r = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            k = MW'(i);
            if (v[k]) r = k;
        end
        return r;
    endfunction

    arb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MW-1:0]          ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [NUM_MASTERS-1:0] pick;
    logic                   pick_vld;
    logic [NUM_MASTERS-1:0] rearb_gnt;
    logic [MW-1:0]          rearb_idx;
    logic [MW-1:0]          gidx;
    logic                   rearb;
    htrans_e                trans;
    hburst_e                burst;

    assign trans = htrans_e'(Htrans);
    assign burst = hburst_e'(Hburst);
    assign gidx  = oh2idx(Hgrant);

    rr_picker #(
        .N (NUM_MASTERS),
        .W (MW)
    ) u_picker (
        .req (Hbusreq),
        .ptr (ptr_q),
        .gnt (pick),
        .vld (pick_vld)
    );

    assign rearb_gnt = pick_vld ? pick : DEF_GNT;
    assign rearb_idx = pick_vld ? oh2idx(pick) : DEF_IDX;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = Hgrant;
        ptr_d   = ptr_q;
        rearb   = 1'b0;
        unique case (state_q)
            ARB: begin
                if (trans == NONSEQ && burst_len(burst) > 1) begin
                    state_d = BURST;
                    cnt_d   = CNT_W'(burst_len(burst) - 1);
                end else if (Hlock[gidx] && Hbusreq[gidx]) begin
                    state_d = LOCKED;
                end else begin
                    rearb = 1'b1;
                end
            end
            BURST: begin
                if (trans == IDLE || trans == NONSEQ) begin
                    rearb   = 1'b1;
                    state_d = ARB;
                    cnt_d   = '0;
                end else if (trans == SEQ) begin
                    // Last beat: hand over so the next owner overlaps it.
                    if (cnt_q < CNT_W'(2)) begin
                        rearb   = 1'b1;
                        state_d = ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (!Hlock[gidx]) begin
                    rearb   = 1'b1;
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = '0;
            end
        endcase
        if (rearb) begin
            grant_d = rearb_gnt;
            if (rearb_gnt != Hgrant) ptr_d = rearb_idx;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= ARB;
            cnt_q     <= '0;
            ptr_q     <= DEF_IDX;
            Hgrant    <= DEF_GNT;
            Hmaster   <= DEF_IDX;
            Hmastlock <= 1'b0;
        end else if (Hready) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            Hgrant    <= grant_d;
            Hmaster   <= gidx;
            Hmastlock <= Hlock[gidx];
        end
    end

    a_grant_onehot: assert property (
        @(posedge Hclk) disable iff (!Hresetn) $onehot(Hgrant)
    );

endmodule
